cic_acq_sequencer: RTL
======================

// Module: cic_acq_sequencer
// PURPOSE
//  Sequences one cic decimator instance through an acquisition: holds it in reset while idle, releases it on start,
//  discards the first SETTLE_SAMPLES decimated outputs (comb not yet primed), then captures burst_len_i samples.
//  Samples are taken on the rising edge of the CIC output strobe (mid-period, data stable).
//  Captured samples are buffered in a small FIFO and delivered downstream over a valid/ready interface.
// PARAMETERS
//  SAMPLE_W        10  width of cic_sample_i / sample_o (matches cic register_width)
//  FIFO_DEPTH      4   output FIFO entries; power of 2, >= 2
//  SETTLE_SAMPLES  2   decimated outputs discarded after CIC reset release; 0 = none discarded
//  BURST_W         16  width of burst_len_i and of the internal burst counter
// PORTS
//  clk_i           in   1         clock; same clock as the cic instance
//  rst_i           in   1         synchronous reset, active-high
//  start_i         in   1         single-cycle pulse: begin an acquisition (honoured in IDLE only)
//  stop_i          in   1         single-cycle pulse: abort the acquisition
//  burst_len_i     in   BURST_W   samples to capture; 0 = continuous until stop_i; sampled on the accepted start
//  cic_rstn_o      out  1         active-low reset to the cic instance
//  cic_strobe_i    in   1         cic decimated-output clock (counter MSB)
//  cic_sample_i    in   SAMPLE_W  cic saturated output
//  sample_o        out  SAMPLE_W  FIFO head data
//  sample_valid_o  out  1         FIFO not empty
//  sample_ready_i  in   1         downstream accept; a pop happens when valid && ready
//  busy_o          out  1         state != IDLE
//  done_o          out  1         single-cycle pulse on DRAIN->IDLE
//  overflow_o      out  1         sticky: a capture was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: state=IDLE, cic_rstn_o=0, FIFO empty, sample_valid_o=0, busy_o=0, done_o=0, overflow_o=0,
//   counters=0, strobe edge register=0.
//  Strobe edge: strb_q <= cic_strobe_i every cycle; strb_q is forced to 0 in IDLE.
//   Edge when cic_strobe_i && !strb_q.
//  FSM:
//   IDLE   - cic_rstn_o=0.
//            start_i && !stop_i: latch burst_len_i, clear overflow_o and counters, go to SETTLE
//            (RUN if SETTLE_SAMPLES==0).
//   SETTLE - cic_rstn_o=1. Count edges; the edge that is number SETTLE_SAMPLES is discarded and moves to RUN.
//            stop_i: go straight to IDLE.
//   RUN    - cic_rstn_o=1. Each edge is a capture: push cic_sample_i and increment the burst count.
//            When the count reaches the latched burst length (nonzero), go to DRAIN in the same cycle as the last push.
//            stop_i: go to DRAIN. A capture in the same cycle as stop_i is still pushed.
//   DRAIN  - cic_rstn_o=0, no captures. When the FIFO is empty: done_o=1 for one cycle and go to IDLE.
//  Latency: an edge seen at cycle t writes the FIFO at the end of t.
//   If the FIFO was empty, sample_valid_o=1 and sample_o=data at t+1.
//  FIFO:
//   - First-word-fall-through; data is stable while valid && !ready.
//   - Push when full: dropped, overflow_o<=1, burst count still increments, so burst length counts strobes.
//   - Push and pop in the same cycle when full: the push is accepted and the occupancy is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; an explicit count of log2(FIFO_DEPTH)+1 bits separates full from empty.
//   - FIFO contents are retained across IDLE; only rst_i flushes them.
//  Ignored events: start_i outside IDLE. start_i && stop_i in IDLE: no acquisition. stop_i in IDLE or DRAIN: no effect.
//  Continuous mode (latched length 0): the burst count saturates at all-ones and never ends RUN.
//  rst_i at any point returns to the reset values in the next cycle, including mid-RUN with data in the FIFO.
// CONFIGURATION
//  CIC_ACQ_TAG_EN defined:
//   - Adds port tag_o (out, BURST_W): 0-based index of the head sample within its burst.
//   - The tag is stored in the FIFO next to the data; its reset value is 0.
//  Not defined: tag_o is absent, the FIFO is SAMPLE_W wide, and the tag logic is not built.
// STRUCTURE
//  Package cic_pkg: typedef enum logic [1:0] cic_acq_state_e {ACQ_IDLE, ACQ_SETTLE, ACQ_RUN, ACQ_DRAIN};
//   localparam helper for the FIFO pointer width.
//  Sub-module cic_acq_fifo: parameterised width/depth FWFT FIFO with push/pop/full/empty/overflow-drop.
//  Top level holds the FSM, edge detect and counters.
// TESTING (bench drives cic_strobe_i as a square wave of period 8, rising on cycles 8k+4)
//  1 rst_i high 3 cycles -> all outputs at reset values; cic_rstn_o=0.
//  2 SETTLE_SAMPLES=2, start_i with burst_len_i=3, ready=1 -> edges 1-2 are discarded; samples from edges 3-5
//    appear one cycle after each edge; done_o pulses once; then busy_o=0 and cic_rstn_o=0.
//  3 ready=0, burst_len_i=6, FIFO_DEPTH=4 -> 4 samples held, 2 dropped, overflow_o=1.
//    Raising ready pops exactly 4 samples in order, then done_o. The next start_i clears overflow_o.
//  4 burst_len_i=0, stop_i after 10 captures -> exactly 10 samples delivered;
//    a capture coinciding with stop_i is included.
//  5 stop_i during SETTLE -> IDLE next cycle, no sample_valid_o, no done_o.
//    start_i && stop_i together in IDLE -> busy_o stays 0.
//  6 rst_i asserted mid-RUN with 3 samples queued -> next cycle sample_valid_o=0, state IDLE, cic_rstn_o=0;
//    with CIC_ACQ_TAG_EN, tag_o reads 0,1,2 in a normal 3-sample burst.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC acquisition sequencer.
package cic_pkg;

    typedef enum logic [1:0] {
        ACQ_IDLE,
        ACQ_SETTLE,
        ACQ_RUN,
        ACQ_DRAIN
    } cic_acq_state_e;

    // Pointer width for a power-of-two FIFO; at least one bit so depth 2 still works.
    localparam int FIFO_PTR_W_MIN = 1;

    function automatic int fifo_ptr_w(input int depth);
        return ($clog2(depth) > FIFO_PTR_W_MIN) ? $clog2(depth) : FIFO_PTR_W_MIN;
    endfunction

endpackage

// File: rtl/cic_acq_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
module cic_acq_fifo
    import cic_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int             PTR_W     = fifo_ptr_w(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             pop_en;
    logic             push_en;

    assign empty_o = (count_reg == '0);
    assign full_o  = (count_reg == DEPTH_CNT);
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    // Head reads as zero while empty so the (optional) tag field has a defined reset value.
    assign head_data_o = empty_o ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_reg[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cic_acq_sequencer.sv
// Drives one CIC decimator through settle/capture/drain and streams captured samples out.
// Optional build macro CIC_ACQ_TAG_EN adds tag_o (index of the head sample within its burst).
module cic_acq_sequencer
    import cic_pkg::*;
#(
    parameter int SAMPLE_W       = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_SAMPLES = 2,
    parameter int BURST_W        = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [BURST_W-1:0]  burst_len_i,
    output logic                cic_rstn_o,
    input  logic                cic_strobe_i,
    input  logic [SAMPLE_W-1:0] cic_sample_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o
`ifdef CIC_ACQ_TAG_EN
    ,
    output logic [BURST_W-1:0]  tag_o
`endif
);

`ifdef CIC_ACQ_TAG_EN
    localparam int FIFO_W = SAMPLE_W + BURST_W;
`else
    localparam int FIFO_W = SAMPLE_W;
`endif
    localparam logic [BURST_W-1:0] SETTLE_CNT = BURST_W'(SETTLE_SAMPLES);

    cic_acq_state_e     state_reg;
    logic               strb_q_reg;
    logic               cic_rstn_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               overflow_reg;
    logic [BURST_W-1:0] burst_len_reg;
    logic [BURST_W-1:0] burst_cnt_reg;
    logic [BURST_W-1:0] settle_cnt_reg;

    logic               strb_edge;
    logic               cap_push;
    logic               pop_fire;
    logic               cap_drop;
    logic               burst_last;
    logic [BURST_W-1:0] burst_inc;
    logic [BURST_W-1:0] settle_inc;
    logic [FIFO_W-1:0]  fifo_push_data;
    logic [FIFO_W-1:0]  fifo_head;
    logic               fifo_empty;
    logic               fifo_full;

    assign strb_edge  = cic_strobe_i && !strb_q_reg;
    assign cap_push   = (state_reg == ACQ_RUN) && strb_edge;
    assign pop_fire   = sample_valid_o && sample_ready_i;
    assign cap_drop   = cap_push && fifo_full && !pop_fire;
    // Burst count saturates so continuous mode never wraps back onto a real length.
    assign burst_inc  = (&burst_cnt_reg) ? burst_cnt_reg : burst_cnt_reg + BURST_W'(1);
    assign settle_inc = settle_cnt_reg + BURST_W'(1);
    assign burst_last = (burst_len_reg != '0) && (burst_inc == burst_len_reg);

`ifdef CIC_ACQ_TAG_EN
    assign fifo_push_data = {burst_cnt_reg, cic_sample_i};
    assign tag_o          = fifo_head[FIFO_W-1:SAMPLE_W];
`else
    assign fifo_push_data = cic_sample_i;
`endif
    assign sample_o       = fifo_head[SAMPLE_W-1:0];
    assign sample_valid_o = !fifo_empty;
    assign cic_rstn_o     = cic_rstn_reg;
    assign busy_o         = busy_reg;
    assign done_o         = done_reg;
    assign overflow_o     = overflow_reg;

    cic_acq_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (cap_push),
        .push_data_i (fifo_push_data),
        .pop_i       (sample_ready_i),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ACQ_IDLE;
            strb_q_reg     <= 1'b0;
            cic_rstn_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            burst_len_reg  <= '0;
            burst_cnt_reg  <= '0;
            settle_cnt_reg <= '0;
        end else begin
            done_reg   <= 1'b0;
            strb_q_reg <= (state_reg == ACQ_IDLE) ? 1'b0 : cic_strobe_i;
            if (cap_drop) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                ACQ_IDLE: begin
                    if (start_i && !stop_i) begin
                        burst_len_reg  <= burst_len_i;
                        burst_cnt_reg  <= '0;
                        settle_cnt_reg <= '0;
                        overflow_reg   <= 1'b0;
                        busy_reg       <= 1'b1;
                        cic_rstn_reg   <= 1'b1;
                        state_reg      <= (SETTLE_SAMPLES == 0) ? ACQ_RUN : ACQ_SETTLE;
                    end
                end
                ACQ_SETTLE: begin
                    if (stop_i) begin
                        busy_reg     <= 1'b0;
                        cic_rstn_reg <= 1'b0;
                        state_reg    <= ACQ_IDLE;
                    end else if (strb_edge) begin
                        settle_cnt_reg <= settle_inc;
                        if (settle_inc == SETTLE_CNT) begin
                            state_reg <= ACQ_RUN;
                        end
                    end
                end
                ACQ_RUN: begin
                    if (strb_edge) begin
                        burst_cnt_reg <= burst_inc;
                    end
                    if (stop_i || (strb_edge && burst_last)) begin
                        cic_rstn_reg <= 1'b0;
                        state_reg    <= ACQ_DRAIN;
                    end
                end
                ACQ_DRAIN: begin
                    if (fifo_empty) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ACQ_IDLE;
                    end
                end
                default: state_reg <= ACQ_IDLE;
            endcase
        end
    end

endmodule
